// File: rtl/square_pair_tx_if.sv
// Start/data request and serial pair outputs of the square generator.
// master drives the operand side; slave is the generator itself.
interface square_pair_tx_if;
    logic        i_Start;
    logic [7:0]  i_Data;
    logic        o_Busy;
    logic [1:0]  o_Pair;
    logic        o_Valid;
    logic        o_Done;
    logic [15:0] o_Square;

    modport master (
        output i_Start, i_Data,
        input  o_Busy, o_Pair, o_Valid, o_Done, o_Square
    );

    modport slave (
        input  i_Start, i_Data,
        output o_Busy, o_Pair, o_Valid, o_Done, o_Square
    );
endinterface

// File: rtl/square_pair_tx.sv
// Squares an 8-bit operand by shift-add and streams the square MSB-first as 2-bit pairs.
// Start to o_Done is 9 + 8*P cycles; no backpressure, i_Start is ignored outside IDLE.
module square_pair_tx #(
    parameter int P_PAIR_PERIOD = 2
) (
    input  logic           i_clk,
    input  logic           i_Reset,
    square_pair_tx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MULT, SEND, DONE} state_t;

    localparam logic [3:0] PER_LAST = 4'(P_PAIR_PERIOD - 1);

    state_t      state, state_nxt;
    logic [7:0]  mcand, mcand_nxt;
    logic [7:0]  mplier, mplier_nxt;
    logic [15:0] acc, acc_nxt;
    logic [15:0] partial;
    logic [15:0] square, square_nxt;
    logic [2:0]  step, step_nxt;
    logic [2:0]  k, k_nxt;
    logic [3:0]  per_cnt, per_cnt_nxt;
    logic        busy, busy_nxt;
    logic        valid, valid_nxt;
    logic        done, done_nxt;
    logic [1:0]  pair, pair_nxt;

    assign partial = mplier[step] ? (16'(mcand) << step) : 16'h0000;

    always_comb begin
        state_nxt   = state;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        acc_nxt     = acc;
        square_nxt  = square;
        step_nxt    = step;
        k_nxt       = k;
        per_cnt_nxt = per_cnt;
        busy_nxt    = busy;
        pair_nxt    = pair;
        valid_nxt   = 1'b0;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                pair_nxt = 2'b00;
                if (bus.i_Start) begin
                    mcand_nxt  = bus.i_Data;
                    mplier_nxt = bus.i_Data;
                    acc_nxt    = 16'h0000;
                    step_nxt   = 3'd0;
                    busy_nxt   = 1'b1;
                    state_nxt  = MULT;
                end
            end
            MULT: begin
                acc_nxt = acc + partial;
                if (step == 3'd7) begin
                    // First pair is launched together with the finished square.
                    square_nxt  = acc + partial;
                    k_nxt       = 3'd7;
                    per_cnt_nxt = 4'd0;
                    valid_nxt   = 1'b1;
                    pair_nxt    = square_nxt[15:14];
                    state_nxt   = SEND;
                end else begin
                    step_nxt = step + 3'd1;
                end
            end
            SEND: begin
                if (per_cnt == PER_LAST) begin
                    per_cnt_nxt = 4'd0;
                    if (k == 3'd0) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pair_nxt  = 2'b00;
                        state_nxt = DONE;
                    end else begin
                        k_nxt     = k - 3'd1;
                        valid_nxt = 1'b1;
                        pair_nxt  = square[{k_nxt, 1'b0} +: 2];
                    end
                end else begin
                    per_cnt_nxt = per_cnt + 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            state   <= IDLE;
            mcand   <= 8'h00;
            mplier  <= 8'h00;
            acc     <= 16'h0000;
            square  <= 16'h0000;
            step    <= 3'd0;
            k       <= 3'd0;
            per_cnt <= 4'd0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b0;
            pair    <= 2'b00;
        end else begin
            state   <= state_nxt;
            mcand   <= mcand_nxt;
            mplier  <= mplier_nxt;
            acc     <= acc_nxt;
            square  <= square_nxt;
            step    <= step_nxt;
            k       <= k_nxt;
            per_cnt <= per_cnt_nxt;
            busy    <= busy_nxt;
            valid   <= valid_nxt;
            done    <= done_nxt;
            pair    <= pair_nxt;
        end
    end

    assign bus.o_Busy   = busy;
    assign bus.o_Pair   = pair;
    assign bus.o_Valid  = valid;
    assign bus.o_Done   = done;
    assign bus.o_Square = square;

endmodule

// File: tb/tb_square_pair_tx.sv
// Directed bench: table of operands/squares checked cycle by cycle against a timing model,
// plus hand sequences for held start, mid-SEND reset and the root loopback.
module tb_square_pair_tx;

    logic       i_clk;
    logic       i_Reset;
    logic       start;
    logic [7:0] data;
    logic       sel;          // 0: P=2 instance, 1: P=1 instance

    int compared;
    int mismatched;

    square_pair_tx_if if2 ();
    square_pair_tx_if if1 ();

    assign if2.i_Start = start & ~sel;
    assign if1.i_Start = start & sel;
    assign if2.i_Data  = data;
    assign if1.i_Data  = data;

    square_pair_tx #(.P_PAIR_PERIOD(2)) dut2 (.i_clk(i_clk), .i_Reset(i_Reset), .bus(if2));
    square_pair_tx #(.P_PAIR_PERIOD(1)) dut1 (.i_clk(i_clk), .i_Reset(i_Reset), .bus(if1));

    // {busy, valid, done, pair[1:0], square[15:0]}
    logic [20:0] obs;
    always_comb begin
        if (sel)
            obs = {if1.o_Busy, if1.o_Valid, if1.o_Done, if1.o_Pair, if1.o_Square};
        else
            obs = {if2.o_Busy, if2.o_Valid, if2.o_Done, if2.o_Pair, if2.o_Square};
    end

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] sq;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] last_sq2;
    logic [15:0] last_sq1;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input int cyc, input logic [20:0] act, input logic [20:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d: got busy/valid/done/pair/sq=%b/%b/%b/%b/%h want %b/%b/%b/%b/%h",
                     name, cyc, act[20], act[19], act[18], act[17:16], act[15:0],
                     exp[20], exp[19], exp[18], exp[17:16], exp[15:0]);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Caller is inside the cycle where start is to be sampled (cycle 0); returns in cycle 10+8P.
    task automatic run_check(input logic [7:0] d, input logic [15:0] sq, input int p,
                             input bit hold, input bit chg, output logic [15:0] rebuilt);
        logic [15:0] prev;
        logic [20:0] exp;
        int kk;
        prev    = sel ? last_sq1 : last_sq2;
        start   = 1'b1;
        data    = d;
        rebuilt = 16'h0000;
        for (int c = 1; c <= 10 + 8 * p; c++) begin
            tick();
            if (!hold) start = 1'b0;
            if (chg && c == 3) data = ~d;
            exp = '0;
            exp[20] = (c >= 1 && c <= 8 + 8 * p);
            exp[19] = (c >= 9 && c < 9 + 8 * p && ((c - 9) % p == 0));
            exp[18] = (c == 9 + 8 * p);
            if (c >= 9 && c < 9 + 8 * p) begin
                kk = 7 - (c - 9) / p;
                exp[17:16] = sq[2 * kk +: 2];
            end
            exp[15:0] = (c >= 9) ? sq : prev;
            check("xfer", c, obs, exp);
            if (obs[19]) rebuilt = {rebuilt[13:0], obs[17:16]};
        end
        if (sel) last_sq1 = sq;
        else     last_sq2 = sq;
    endtask

    initial begin
        logic [15:0] rb;
        int quiet_bad;

        vecs[0] = '{8'd255, 16'hFE01};
        vecs[1] = '{8'd13,  16'h00A9};
        vecs[2] = '{8'd200, 16'h9C40};
        vecs[3] = '{8'd1,   16'h0001};
        vecs[4] = '{8'd170, 16'h70E4};
        vecs[5] = '{8'd128, 16'h4000};

        compared   = 0;
        mismatched = 0;
        start      = 1'b0;
        data       = 8'h00;
        sel        = 1'b0;
        last_sq2   = 16'h0000;
        last_sq1   = 16'h0000;
        i_Reset    = 1'b1;
        repeat (3) tick();
        check("reset_p2", 0, obs, 21'h0);
        sel = 1'b1;
        #1;
        check("reset_p1", 0, obs, 21'h0);
        sel = 1'b0;
        i_Reset = 1'b0;
        tick();

        // P=2 table, back-to-back at the earliest legal start
        for (int i = 0; i < 6; i++) begin
            run_check(vecs[i].data, vecs[i].sq, 2, 1'b0, 1'b0, rb);
            check_val("rebuilt_p2", int'(rb), int'(vecs[i].sq));
            if (vecs[i].data == 8'd200)
                check_val("loopback_root", isqrt(int'(rb)), 200);
        end

        // held start with operand change mid-MULT, then immediate second transfer
        run_check(8'd77, 16'h1729, 2, 1'b1, 1'b1, rb);
        run_check(8'd16, 16'h0100, 2, 1'b0, 1'b0, rb);

        // P=1 instance
        sel = 1'b1;
        tick();
        run_check(8'd0,   16'h0000, 1, 1'b0, 1'b0, rb);
        run_check(8'd255, 16'hFE01, 1, 1'b0, 1'b0, rb);
        check_val("rebuilt_p1", int'(rb), 16'hFE01);

        // reset during the third SEND period (cycles 13..14 at P=2)
        sel   = 1'b0;
        tick();
        start = 1'b1;
        data  = 8'd255;
        for (int c = 1; c <= 13; c++) begin
            tick();
            start = 1'b0;
        end
        check("pre_reset_pair", 13, obs, {1'b1, 1'b1, 1'b0, 2'b11, 16'hFE01});
        i_Reset = 1'b1;
        tick();
        check("rst_abort", 14, obs, 21'h0);
        i_Reset   = 1'b0;
        quiet_bad = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (obs[20] || obs[19] || obs[18]) quiet_bad++;
        end
        check_val("rst_quiet", quiet_bad, 0);
        last_sq2 = 16'h0000;
        run_check(8'd16, 16'h0100, 2, 1'b0, 1'b0, rb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/square_pair_tx.md
# square_pair_tx

Bit-serial square generator: the transmit end of the 2-bit-pair stream that the root engine consumes. Latches an 8-bit value, squares it with an 8-step shift-add multiplier, then emits the 16-bit square MSB-first as eight 2-bit pairs, one pair per pacing period. It sits between the switch/button front end and the root engine, giving a self-check loop: root(square(x)) must equal x on the seven-segment display.

## Interface
- P_PAIR_PERIOD, 2, i_clk cycles per emitted pair. Legal range 1..16; the default matches the root engine's half-rate clock.
- i_clk  in  1  system clock; all logic on posedge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Start  in  1  start request, sampled only in IDLE.
- i_Data  in  8  unsigned operand, latched on an accepted start.
- o_Busy  out  1  high in MULT and SEND.
- o_Pair  out  2  current pair: square bits [2k+1:2k].
- o_Valid  out  1  one-cycle strobe at the start of each pair period.
- o_Done  out  1  one-cycle pulse after the last pair period.
- o_Square  out  16  last completed square, held.

## Operation
- States: IDLE, MULT, SEND, DONE. All outputs are registered.
- IDLE: o_Busy=0. When i_Start=1:
  - latch i_Data into multiplicand and multiplier;
  - clear the 16-bit accumulator and step counter;
  - go to MULT.
- MULT runs exactly 8 cycles, for step s=0..7:
  - if multiplier bit s = 1, then acc += multiplicand << s;
  - the result never overflows 16 bits (255² = 65025);
  - after step 7, load o_Square with acc, set pair index k=7, go to SEND.
- SEND drives o_Pair = o_Square[2k+1:2k] for P_PAIR_PERIOD cycles.
  - o_Valid is high only on the first cycle of each period;
  - o_Pair holds for the whole period;
  - k decrements after each period; after the k=0 period ends, go to DONE.
- DONE: o_Done=1 and o_Busy=0 for one cycle, then IDLE. i_Start is ignored in DONE.
- i_Start is ignored in MULT, SEND and DONE. There is no queuing.
- i_Data is only sampled on an accepted start; changes at any other time have no effect.
- i_Reset=1 (any state, including mid-MULT or mid-SEND):
  - next state is IDLE;
  - o_Busy, o_Valid, o_Done = 0; o_Pair = 2'b00; o_Square = 16'h0000;
  - the accumulator and counters are cleared;
  - the aborted transfer produces no o_Done.
- Reset has priority over i_Start in the same cycle.
- o_Pair outside SEND is 2'b00.
- o_Square is unchanged during MULT until step 7 completes.

## Timing
- Cycle 0 is the cycle in which i_Start=1 is sampled in IDLE.
- Cycles 1..8: MULT, o_Busy=1.
- Cycle 9: o_Square holds the new value; first o_Valid, carrying pair k=7.
- Pair k (k=7..0) o_Valid occurs at cycle 9 + (7−k)·P_PAIR_PERIOD.
- o_Busy is high from cycle 1 through cycle 8 + 8·P_PAIR_PERIOD.
- o_Done is at cycle 9 + 8·P_PAIR_PERIOD.
- The earliest next accepted start is cycle 10 + 8·P_PAIR_PERIOD.
- Total latency, start to o_Done: 9 + 8·P cycles; 25 cycles at the default P=2.

## Test plan
- Reset, then i_Data=8'd255 with a start pulse, P=2:
  - o_Square=16'hFE01 at cycle 9;
  - pairs 11,11,11,10,00,00,00,01 on o_Valid at cycles 9,11,…,23;
  - o_Done at cycle 25.
- i_Data=8'd13, P=2:
  - o_Square=16'h00A9;
  - pairs 00,00,00,00,10,10,10,01;
  - o_Pair stable during both cycles of each period.
- i_Data=8'd0 with P=1:
  - o_Square=0; eight consecutive o_Valid strobes at cycles 9..16, all pairs 00;
  - o_Done at cycle 17;
  - o_Busy high cycles 1..16.
- i_Start held high throughout a transfer with i_Data changing mid-MULT:
  - only one transfer runs, using the value latched at cycle 0;
  - the next transfer starts at cycle 10+8P, latching the i_Data present then.
- i_Reset=1 for one cycle in the third SEND period:
  - next cycle all outputs are 0 and the state is IDLE;
  - no o_Done and no further o_Valid;
  - a subsequent start of 8'd16 yields 16'h0100.
- Loopback with the root engine, i_Data=8'd200:
  - root result = 200 on the display.
